// File: rtl/window_align_stream.sv
`default_nettype none
// ============================================================================
// Module      : window_align_stream
// Description : Streaming word-offset realigner for multi-word line beats.
//               Each output beat is a funnel shift across two consecutive
//               input beats (tail of the held beat, head of the next beat),
//               using an offset latched on the first beat of each line. The
//               end of a line is flushed against an all-zero beat.
//               Write addresses of the held beat travel with the output.
// Ports       : clk, rst_n               - clock, async active-low reset
//               cfg_offset              - word offset, sampled on accepted sol
//               in_valid/in_ready       - input handshake
//               in_sol/in_eol           - input line framing
//               in_data                 - input beat (word x at x*WORD_SIZE)
//               in_addr_y/in_addr_block - input write addresses
//               out_valid/out_ready     - output handshake
//               out_data                - aligned beat
//               out_addr_y/out_addr_block - addresses of the producing beat
//               out_eol                 - last output beat of a line
//               err_sol                 - sticky: sol seen mid-line
// Revision    : 1.0 - initial streaming release
// ============================================================================
module window_align_stream #(
    parameter int WORDS       = 8,
    parameter int WORD_SIZE   = 8,
    parameter int INDEX_WIDTH = 10,
    parameter int OFF_W       = $clog2(WORDS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [OFF_W-1:0]             cfg_offset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sol,
    input  logic                         in_eol,
    input  logic [WORDS*WORD_SIZE-1:0]   in_data,
    input  logic [INDEX_WIDTH-1:0]       in_addr_y,
    input  logic [INDEX_WIDTH-1:0]       in_addr_block,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORDS*WORD_SIZE-1:0]   out_data,
    output logic [INDEX_WIDTH-1:0]       out_addr_y,
    output logic [INDEX_WIDTH-1:0]       out_addr_block,
    output logic                         out_eol,
    output logic                         err_sol
);

    localparam int c_BEAT_W = WORDS * WORD_SIZE;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [c_BEAT_W-1:0]      r_held;
    logic [INDEX_WIDTH-1:0]   r_addr_y;
    logic [INDEX_WIDTH-1:0]   r_addr_blk;
    logic [OFF_W-1:0]         r_off;

    logic                     r_out_valid;
    logic [c_BEAT_W-1:0]      r_out_data;
    logic [INDEX_WIDTH-1:0]   r_out_addr_y;
    logic [INDEX_WIDTH-1:0]   r_out_addr_blk;
    logic                     r_out_eol;
    logic                     r_err_sol;

    logic                     w_out_free;
    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_prime;
    logic                     w_emit_stream;
    logic                     w_emit_flush;
    logic                     w_err_set;

    logic [c_BEAT_W-1:0]      w_nxt;
    logic [2*c_BEAT_W-1:0]    w_cat;
    logic [c_BEAT_W-1:0]      w_aligned;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Handshake, next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_out_free    = !r_out_valid || out_ready;
        w_in_ready    = (r_state != S_FLUSH) && w_out_free;
        w_accept      = in_valid && w_in_ready;
        w_prime       = 1'b0;
        w_emit_stream = 1'b0;
        w_emit_flush  = 1'b0;
        w_err_set     = 1'b0;
        w_state_nxt   = r_state;

        case (r_state)
            S_IDLE: begin
                // Beats without sol are accepted and dropped here.
                if (w_accept && in_sol) begin
                    w_prime     = 1'b1;
                    w_state_nxt = in_eol ? S_FLUSH : S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_accept) begin
                    if (in_sol) begin
                        // New line starts before the old one ended: drop the
                        // held beat and re-prime. A sol+eol beat here is a
                        // complete one-beat line, so it flushes like in IDLE.
                        w_prime   = 1'b1;
                        w_err_set = 1'b1;
                    end else begin
                        w_emit_stream = 1'b1;
                    end
                    if (in_eol) begin
                        w_state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (w_out_free) begin
                    w_emit_flush = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Funnel shift: {next, held} viewed as 2*WORDS words, output word x
    // is word x+offset of that concatenation. The flush uses a zero beat.
    // ------------------------------------------------------------------
    always_comb begin
        w_nxt     = (r_state == S_FLUSH) ? '0 : in_data;
        w_cat     = {w_nxt, r_held};
        w_aligned = '0;
        for (int x = 0; x < WORDS; x++) begin
            w_aligned[x*WORD_SIZE +: WORD_SIZE] =
                w_cat[(x + int'(r_off))*WORD_SIZE +: WORD_SIZE];
        end
    end

    // ------------------------------------------------------------------
    // Held beat, latched offset and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held         <= '0;
            r_addr_y       <= '0;
            r_addr_blk     <= '0;
            r_off          <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_addr_y   <= '0;
            r_out_addr_blk <= '0;
            r_out_eol      <= 1'b0;
            r_err_sol      <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Emission only happens when the output register is free, so a
            // new load never overwrites an unconsumed beat.
            if (w_emit_stream || w_emit_flush) begin
                r_out_valid    <= 1'b1;
                r_out_data     <= w_aligned;
                r_out_addr_y   <= r_addr_y;
                r_out_addr_blk <= r_addr_blk;
                r_out_eol      <= w_emit_flush;
            end
            if (w_prime || w_emit_stream) begin
                r_held     <= in_data;
                r_addr_y   <= in_addr_y;
                r_addr_blk <= in_addr_block;
            end
            if (w_prime) begin
                r_off <= cfg_offset;
            end
            if (w_err_set) begin
                r_err_sol <= 1'b1;
            end
        end
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_addr_y     = r_out_addr_y;
    assign out_addr_block = r_out_addr_blk;
    assign out_eol        = r_out_eol;
    assign err_sol        = r_err_sol;

endmodule
`default_nettype wire

// File: tb/tb_window_align_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_align_stream
// Description : Self-checking bench for window_align_stream (WORDS=4,
//               WORD_SIZE=8). Directed line scenarios with literal
//               expectations, then randomized lines and backpressure checked
//               every cycle against a transaction-level line model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_align_stream;

    localparam int c_W  = 4;
    localparam int c_WS = 8;
    localparam int c_IW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        cfg_offset = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sol = 1'b0;
    logic              in_eol = 1'b0;
    logic [31:0]       in_data = '0;
    logic [c_IW-1:0]   in_addr_y = '0;
    logic [c_IW-1:0]   in_addr_block = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_data;
    logic [c_IW-1:0]   out_addr_y;
    logic [c_IW-1:0]   out_addr_block;
    logic              out_eol;
    logic              err_sol;

    int n_cmp  = 0;
    int n_fail = 0;

    bit ready_mode   = 1'b0;   // 1: random out_ready
    bit forced_ready = 1'b1;

    window_align_stream #(
        .WORDS       (c_W),
        .WORD_SIZE   (c_WS),
        .INDEX_WIDTH (c_IW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_offset     (cfg_offset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sol         (in_sol),
        .in_eol         (in_eol),
        .in_data        (in_data),
        .in_addr_y      (in_addr_y),
        .in_addr_block  (in_addr_block),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_addr_y     (out_addr_y),
        .out_addr_block (out_addr_block),
        .out_eol        (out_eol),
        .err_sol        (err_sol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready = ready_mode ? ($urandom_range(0, 9) < 7) : forced_ready;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] w4(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    // Word x of the result: word x+o of the held beat, or of the next beat
    // once x+o runs past the end of the held beat.
    function automatic logic [31:0] m_align(input logic [31:0] h, input logic [31:0] n, input int o);
        logic [31:0] r;
        r = '0;
        for (int x = 0; x < c_W; x++) begin
            if (x + o < c_W) r[x*c_WS +: c_WS] = h[(x+o)*c_WS +: c_WS];
            else             r[x*c_WS +: c_WS] = n[(x+o-c_W)*c_WS +: c_WS];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Line model: queue of expected output beats. 'shown' means the queue
    // front should currently be presented on the output.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0]     d;
        logic [c_IW-1:0] ay;
        logic [c_IW-1:0] ab;
        logic            eol;
        logic            fl;
    } item_t;

    item_t           q[$];
    bit              shown;
    bit              m_in_line;
    bit              m_err;
    logic [31:0]     m_held;
    logic [c_IW-1:0] m_ay, m_ab;
    int              m_off;

    always @(negedge clk) begin
        bit    flush_pend, exp_ready, acc;
        item_t it;
        if (!rst_n) begin
            q.delete();
            shown     = 1'b0;
            m_in_line = 1'b0;
            m_err     = 1'b0;
            m_held    = '0;
            m_ay      = '0;
            m_ab      = '0;
            m_off     = 0;
        end else begin
            // A flush beat waiting for the output register blocks input.
            flush_pend = (q.size() > 0) && q[q.size()-1].fl && !(shown && q.size() == 1);
            exp_ready  = !flush_pend && (!shown || out_ready);

            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("out_valid", 64'(out_valid), 64'(shown));
            check("err_sol", 64'(err_sol), 64'(m_err));
            if (shown && q.size() > 0) begin
                check("out_data", 64'(out_data), 64'(q[0].d));
                check("out_addr_y", 64'(out_addr_y), 64'(q[0].ay));
                check("out_addr_block", 64'(out_addr_block), 64'(q[0].ab));
                check("out_eol", 64'(out_eol), 64'(q[0].eol));
            end

            // Advance the model to the state after the coming rising edge.
            acc = in_valid && exp_ready;
            if (shown && out_ready) begin
                void'(q.pop_front());
                shown = 1'b0;
            end
            if (!shown && q.size() > 0 && q[0].fl) shown = 1'b1;
            if (acc) begin
                if (in_sol) begin
                    if (m_in_line) m_err = 1'b1;
                    m_held = in_data; m_ay = in_addr_y; m_ab = in_addr_block;
                    m_off  = int'(cfg_offset);
                    m_in_line = 1'b1;
                end else if (m_in_line) begin
                    it = '{d: m_align(m_held, in_data, m_off), ay: m_ay, ab: m_ab, eol: 1'b0, fl: 1'b0};
                    q.push_back(it);
                    shown  = 1'b1;
                    m_held = in_data; m_ay = in_addr_y; m_ab = in_addr_block;
                end
                if (m_in_line && in_eol) begin
                    it = '{d: m_align(m_held, 32'h0, m_off), ay: m_ay, ab: m_ab, eol: 1'b1, fl: 1'b1};
                    q.push_back(it);
                    m_in_line = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all drive at rising edge + 1)
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit sol, input bit eol, input logic [31:0] d,
                        input logic [c_IW-1:0] ay, input logic [c_IW-1:0] ab);
        in_valid = 1'b1; in_sol = sol; in_eol = eol;
        in_data = d; in_addr_y = ay; in_addr_block = ab;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                // Framing and data are don't-care while not valid.
                in_sol  = 1'($urandom_range(0, 1));
                in_eol  = 1'($urandom_range(0, 1));
                in_data = $urandom;
                return;
            end
            @(posedge clk); #1;
        end
        n_cmp++; n_fail++;
        $display("FAIL beat_accept_timeout: got no in_ready expected acceptance within 200 cycles");
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] d, input bit eol,
                              input logic [c_IW-1:0] ay);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                check({name, "_data"}, 64'(out_data), 64'(d));
                check({name, "_eol"}, 64'(out_eol), 64'(eol));
                check({name, "_addr_y"}, 64'(out_addr_y), 64'(ay));
                @(posedge clk); #1;
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL %s_timeout: got no output expected one within 40 cycles", name);
        @(posedge clk); #1;
    endtask

    localparam logic [31:0] c_A = 32'h03020100;
    localparam logic [31:0] c_B = 32'h13121110;
    localparam logic [31:0] c_C = 32'h23222120;
    localparam logic [31:0] c_D = 32'h33323130;

    initial begin
        int len;
        bit s;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_addr_y", 64'(out_addr_y), 64'(0));
        check("rst_out_addr_block", 64'(out_addr_block), 64'(0));
        check("rst_out_eol", 64'(out_eol), 64'(0));
        check("rst_err_sol", 64'(err_sol), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(1);

        // Basic realign, o=1
        cfg_offset = 2'd1;
        beat(1, 0, c_A, 10'h010, 10'h020);
        beat(0, 1, c_B, 10'h011, 10'h021);
        expect_out("basic1", w4(8'h01, 8'h02, 8'h03, 8'h10), 0, 10'h010);
        expect_out("basic2", w4(8'h11, 8'h12, 8'h13, 8'h00), 1, 10'h011);
        cycles(1);
        check("basic_idle_ready", 64'(in_ready), 64'(1));

        // Passthrough, o=0
        cfg_offset = 2'd0;
        beat(1, 0, c_A, 10'h030, 10'h0);
        beat(0, 0, c_B, 10'h031, 10'h0);
        expect_out("pass1", c_A, 0, 10'h030);
        beat(0, 1, c_C, 10'h032, 10'h0);
        expect_out("pass2", c_B, 0, 10'h031);
        expect_out("pass3", c_C, 1, 10'h032);

        // Max offset with backpressure
        cfg_offset = 2'd3;
        beat(1, 0, c_A, 10'h040, 10'h0);
        beat(0, 1, c_B, 10'h041, 10'h0);
        forced_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_data", 64'(out_data), 64'(w4(8'h03, 8'h10, 8'h11, 8'h12)));
            check("stall_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk); #1;
        forced_ready = 1'b1;
        expect_out("stall1", w4(8'h03, 8'h10, 8'h11, 8'h12), 0, 10'h040);
        expect_out("stall2", w4(8'h13, 8'h00, 8'h00, 8'h00), 1, 10'h041);

        // Single-beat line, o=2
        cfg_offset = 2'd2;
        beat(1, 1, c_A, 10'h050, 10'h0);
        expect_out("single", w4(8'h02, 8'h03, 8'h00, 8'h00), 1, 10'h050);
        cycles(3);
        check("single_no_extra", 64'(out_valid), 64'(0));

        // Framing errors, o=1
        cfg_offset = 2'd1;
        beat(0, 0, c_D, 10'h060, 10'h0);
        cycles(2);
        check("stray_no_output", 64'(out_valid), 64'(0));
        beat(1, 0, c_A, 10'h061, 10'h0);
        beat(0, 0, c_B, 10'h062, 10'h0);
        expect_out("frame_ab", w4(8'h01, 8'h02, 8'h03, 8'h10), 0, 10'h061);
        beat(1, 0, c_C, 10'h063, 10'h0);
        check("frame_err", 64'(err_sol), 64'(1));
        beat(0, 1, c_D, 10'h064, 10'h0);
        expect_out("frame_cd", w4(8'h21, 8'h22, 8'h23, 8'h30), 0, 10'h063);
        expect_out("frame_d0", w4(8'h31, 8'h32, 8'h33, 8'h00), 1, 10'h064);
        cycles(2);
        check("frame_err_sticky", 64'(err_sol), 64'(1));

        // Offset latch, then mid-line reset
        cfg_offset = 2'd1;
        beat(1, 0, c_A, 10'h070, 10'h0);
        cfg_offset = 2'd2;
        beat(0, 0, c_B, 10'h071, 10'h0);
        expect_out("latch1", w4(8'h01, 8'h02, 8'h03, 8'h10), 0, 10'h070);
        forced_ready = 1'b0;
        beat(0, 0, c_C, 10'h072, 10'h0);
        check("latch2_data", 64'(out_data), 64'(w4(8'h11, 8'h12, 8'h13, 8'h20)));
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_err", 64'(err_sol), 64'(0));
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        forced_ready = 1'b1;
        rst_n = 1'b1;
        cycles(4);
        check("post_rst_no_output", 64'(out_valid), 64'(0));
        check("post_rst_ready", 64'(in_ready), 64'(1));

        // Randomized lines with random backpressure
        ready_mode = 1'b1;
        for (int l = 0; l < 60; l++) begin
            if ($urandom_range(0, 9) == 0)
                beat(0, 1'($urandom_range(0, 1)), $urandom, 10'($urandom), 10'($urandom));
            len = $urandom_range(1, 5);
            cfg_offset = 2'($urandom_range(0, 3));
            for (int b = 0; b < len; b++) begin
                s = (b == 0) || ($urandom_range(0, 19) == 0);
                beat(s, b == len - 1, $urandom, 10'($urandom), 10'($urandom));
                cfg_offset = 2'($urandom_range(0, 3));
            end
        end

        // Drain
        ready_mode   = 1'b0;
        forced_ready = 1'b1;
        cycles(20);
        check("drain_empty", 64'(q.size()), 64'(0));
        check("drain_out_valid", 64'(out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
